// File: rtl/ng_rupt_ctl_if.sv
// Interrupt-unit / sequencer side bundle for ng_rupt_ctl.
// master drives requests and data, slave is the entry/exit sequencer.
interface ng_rupt_ctl_if;
    localparam int unsigned DATA_W = 16;

    logic              RUPT_REQ;
    logic              INST_END;
    logic              INH_EXT;
    logic              RESUME;
    logic [DATA_W-1:0] INT_BUS;
    logic [DATA_W-1:0] Z_IN;

    logic              RPT_N;
    logic              KRPT_N;
    logic              CLRP_N;
    logic              SAVE_Z;
    logic              LOAD_Z;
    logic [DATA_W-1:0] Z_OUT;
    logic              IN_RUPT;
    logic              RUPT_LOCK;

    modport master (
        output RUPT_REQ, INST_END, INH_EXT, RESUME, INT_BUS, Z_IN,
        input  RPT_N, KRPT_N, CLRP_N, SAVE_Z, LOAD_Z, Z_OUT, IN_RUPT, RUPT_LOCK
    );

    modport slave (
        input  RUPT_REQ, INST_END, INH_EXT, RESUME, INT_BUS, Z_IN,
        output RPT_N, KRPT_N, CLRP_N, SAVE_Z, LOAD_Z, Z_OUT, IN_RUPT, RUPT_LOCK
    );
endinterface

// File: rtl/ng_rupt_ctl.sv
// AGC interrupt entry/exit sequencer: RPT/KRPT/CLRP pulses, Z save/redirect/restore.
// Optional lock watchdog enabled by defining RUPT_LOCK_EN.
module ng_rupt_ctl #(
    parameter int unsigned      CNT_W      = 12,
    parameter logic [CNT_W-1:0] LOCK_LIMIT = 12'd3000
) (
    input logic          CLK2,
    input logic          GENRST,
    ng_rupt_ctl_if.slave rif
);
    localparam int unsigned DATA_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RPT  = 3'd1,
        ST_VEC  = 3'd2,
        ST_JMP  = 3'd3,
        ST_ACT  = 3'd4,
        ST_EXIT = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic              rpt_n_q, krpt_n_q, clrp_n_q, save_z_q, load_z_q, in_rupt_q;
    logic              rpt_n_d, krpt_n_d, clrp_n_d, save_z_d, load_z_d, in_rupt_d;
    logic [DATA_W-1:0] z_out_q, z_out_d;
    logic [DATA_W-1:0] zsave_q;
    logic              lock_hit_c;

    // State register plus registered Moore outputs; Z_OUT doubles as the vector register.
    always_ff @(posedge CLK2) begin
        if (GENRST) begin
            state_q   <= ST_IDLE;
            rpt_n_q   <= 1'b1;
            krpt_n_q  <= 1'b1;
            clrp_n_q  <= 1'b1;
            save_z_q  <= 1'b0;
            load_z_q  <= 1'b0;
            in_rupt_q <= 1'b0;
            z_out_q   <= '0;
            zsave_q   <= '0;
        end else begin
            state_q   <= state_d;
            rpt_n_q   <= rpt_n_d;
            krpt_n_q  <= krpt_n_d;
            clrp_n_q  <= clrp_n_d;
            save_z_q  <= save_z_d;
            load_z_q  <= load_z_d;
            in_rupt_q <= in_rupt_d;
            z_out_q   <= z_out_d;
            if (state_q == ST_VEC) zsave_q <= rif.Z_IN;
        end
    end

    // Next state, then outputs decoded from the next state so they register in step.
    always_comb begin
        state_d   = state_q;
        rpt_n_d   = 1'b1;
        krpt_n_d  = 1'b1;
        clrp_n_d  = 1'b1;
        save_z_d  = 1'b0;
        load_z_d  = 1'b0;
        in_rupt_d = 1'b0;
        z_out_d   = z_out_q;

        unique case (state_q)
            ST_IDLE: if (rif.INST_END && rif.RUPT_REQ && !rif.INH_EXT) state_d = ST_RPT;
            ST_RPT:  state_d = ST_VEC;
            ST_VEC: begin
                state_d = ST_JMP;
                z_out_d = rif.INT_BUS;
            end
            ST_JMP:  state_d = ST_ACT;
            ST_ACT: begin
                if (rif.RESUME || lock_hit_c) begin
                    state_d = ST_EXIT;
                    z_out_d = zsave_q;
                end
            end
            ST_EXIT: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        unique case (state_d)
            ST_RPT:  rpt_n_d = 1'b0;
            ST_VEC: begin
                krpt_n_d = 1'b0;
                save_z_d = 1'b1;
            end
            ST_JMP:  load_z_d = 1'b1;
            ST_ACT:  in_rupt_d = 1'b1;
            ST_EXIT: begin
                clrp_n_d = 1'b0;
                load_z_d = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef RUPT_LOCK_EN
    logic [CNT_W-1:0] cnt_q;
    logic             lock_q;

    assign lock_hit_c = (state_q == ST_ACT) && (cnt_q == CNT_W'(LOCK_LIMIT - 1'b1));

    // Saturating ACT-cycle counter; cleared on the way into ACT.
    always_ff @(posedge CLK2) begin
        if (GENRST) begin
            cnt_q <= '0;
        end else if (state_q == ST_JMP) begin
            cnt_q <= '0;
        end else if ((state_q == ST_ACT) && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Sticky lock flag; a coincident RESUME takes the normal exit instead.
    always_ff @(posedge CLK2) begin
        if (GENRST) begin
            lock_q <= 1'b0;
        end else if (lock_hit_c && !rif.RESUME) begin
            lock_q <= 1'b1;
        end
    end

    assign rif.RUPT_LOCK = lock_q;
`else
    logic unused_lock_cfg;

    assign lock_hit_c      = 1'b0;
    assign unused_lock_cfg = ^LOCK_LIMIT;
    assign rif.RUPT_LOCK   = 1'b0;
`endif

    assign rif.RPT_N   = rpt_n_q;
    assign rif.KRPT_N  = krpt_n_q;
    assign rif.CLRP_N  = clrp_n_q;
    assign rif.SAVE_Z  = save_z_q;
    assign rif.LOAD_Z  = load_z_q;
    assign rif.Z_OUT   = z_out_q;
    assign rif.IN_RUPT = in_rupt_q;
endmodule

// File: tb/tb_ng_rupt_ctl.sv
// Scoreboard bench for ng_rupt_ctl: interval-based reference model vs. per-cycle monitor.
// Watchdog expectations follow the RUPT_LOCK_EN define of the build.
module tb_ng_rupt_ctl;
    localparam int MAXC = 8192;
    localparam int BIG  = 1 << 30;
    localparam int LIM  = 8;

    localparam logic [4:0] K_RPT  = 5'b10000;
    localparam logic [4:0] K_VEC  = 5'b01100;
    localparam logic [4:0] K_JMP  = 5'b00010;
    localparam logic [4:0] K_EXIT = 5'b00011;

    typedef struct {
        int         cyc;
        logic [4:0] kind;
    } ev_t;

    logic CLK2 = 1'b0;
    logic GENRST;
    int   ecnt = 0;
    int   checks = 0;
    int   errors = 0;

    ng_rupt_ctl_if rif ();

    ng_rupt_ctl #(
        .CNT_W     (12),
        .LOCK_LIMIT(12'd8)
    ) dut (
        .CLK2  (CLK2),
        .GENRST(GENRST),
        .rif   (rif)
    );

    always #5 CLK2 = ~CLK2;
    always @(posedge CLK2) ecnt <= ecnt + 1;

    // Reference model state: one sequence described by its entry edge and exit cycle.
    ev_t         q[$];
    bit          busy = 0;
    bit          lock = 0;
    int          ent = 0;
    int          ex = BIG;
    logic [15:0] saved = '0;
    logic [15:0] z_track = '0;
    bit          exp_in[MAXC];
    bit          exp_lock[MAXC];
    logic [15:0] exp_z[MAXC];

    function automatic bit in_act(input int c);
        return busy && (c >= ent + 3) && (c < ex);
    endfunction

    task automatic model(input int e, input bit rst, input bit ie, input bit req,
                         input bit inh, input bit res, input logic [15:0] zin,
                         input logic [15:0] ib);
        bit idle_prev;
        bit act_prev;
        if (rst) begin
            while (q.size() > 0 && q[$].cyc >= e) void'(q.pop_back());
            busy    = 0;
            lock    = 0;
            ex      = BIG;
            z_track = '0;
        end else begin
            idle_prev = !busy || (e - 1 > ex);
            act_prev  = in_act(e - 1);
            if (busy && e == ent + 2) begin
                saved   = zin;
                z_track = ib;
                q.push_back('{e, K_JMP});
            end
            if (act_prev && res) begin
                ex = e;
                z_track = saved;
                q.push_back('{e, K_EXIT});
            end
`ifdef RUPT_LOCK_EN
            else if (act_prev && ((e - 1) - (ent + 3)) == LIM - 1) begin
                ex = e;
                z_track = saved;
                lock = 1;
                q.push_back('{e, K_EXIT});
            end
`endif
            else if (idle_prev && ie && req && !inh) begin
                busy = 1;
                ent  = e;
                ex   = BIG;
                q.push_back('{e, K_RPT});
                q.push_back('{e + 1, K_VEC});
            end
        end
        if (e < MAXC) begin
            exp_in[e]   = in_act(e);
            exp_lock[e] = lock;
            exp_z[e]    = z_track;
        end
    endtask

    logic [15:0] zin_v = '0;
    logic [15:0] ib_v = '0;

    // Apply inputs for the next edge, update the model for that edge, then pass it.
    task automatic drive(input bit rst, input bit ie, input bit req, input bit inh, input bit res);
        GENRST       = rst;
        rif.INST_END = ie;
        rif.RUPT_REQ = req;
        rif.INH_EXT  = inh;
        rif.RESUME   = res;
        rif.Z_IN     = zin_v;
        rif.INT_BUS  = ib_v;
        model(ecnt + 1, rst, ie, req, inh, res, zin_v, ib_v);
        @(posedge CLK2);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0);
    endtask

    // Monitor: every cycle compare pulse pattern, IN_RUPT, RUPT_LOCK and Z_OUT.
    logic [4:0] mk;
    ev_t        me;
    always @(negedge CLK2) begin
        if (ecnt >= 1 && ecnt < MAXC) begin
            mk = {~rif.RPT_N, ~rif.KRPT_N, rif.SAVE_Z, rif.LOAD_Z, ~rif.CLRP_N};
            checks++;
            if (q.size() > 0 && q[0].cyc == ecnt) begin
                me = q.pop_front();
                if (mk !== me.kind) begin
                    errors++;
                    $display("FAIL event cyc=%0d got=%b exp=%b", ecnt, mk, me.kind);
                end
            end else if (mk !== 5'b0) begin
                errors++;
                $display("FAIL unexpected_pulse cyc=%0d got=%b exp=00000", ecnt, mk);
            end
            checks++;
            if (rif.IN_RUPT !== exp_in[ecnt]) begin
                errors++;
                $display("FAIL in_rupt cyc=%0d got=%b exp=%b", ecnt, rif.IN_RUPT, exp_in[ecnt]);
            end
            checks++;
            if (rif.RUPT_LOCK !== exp_lock[ecnt]) begin
                errors++;
                $display("FAIL rupt_lock cyc=%0d got=%b exp=%b", ecnt, rif.RUPT_LOCK, exp_lock[ecnt]);
            end
            checks++;
            if (rif.Z_OUT !== exp_z[ecnt]) begin
                errors++;
                $display("FAIL z_out cyc=%0d got=%o exp=%o", ecnt, rif.Z_OUT, exp_z[ecnt]);
            end
        end
    end

    initial begin
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        idle(2);

        // Basic entry and exit with the documented octal values.
        zin_v = 16'o4000;
        ib_v  = 16'o2004;
        drive(0, 1, 1, 0, 0);
        idle(4);
        drive(0, 1, 1, 0, 0);
        drive(0, 1, 1, 0, 0);
        idle(2);
        drive(0, 0, 1, 0, 1);
        idle(3);

        // Blocked or inert requests in IDLE.
        drive(0, 1, 1, 1, 0);
        idle(2);
        drive(0, 0, 0, 0, 1);
        drive(0, 1, 0, 0, 0);
        idle(2);

        // Reset in the VEC cycle, then a clean entry.
        zin_v = 16'o1234;
        ib_v  = 16'o7777;
        drive(0, 1, 1, 0, 0);
        idle(1);
        drive(1, 0, 0, 0, 0);
        idle(2);
        ib_v = 16'o2020;
        drive(0, 1, 1, 0, 0);
        idle(5);
        drive(0, 0, 0, 0, 1);
        idle(3);

        // RESUME coincident with a new request, then entry only from a later INST_END.
        zin_v = 16'o4444;
        ib_v  = 16'o2010;
        drive(0, 1, 1, 0, 0);
        idle(4);
        drive(0, 1, 1, 0, 1);
        drive(0, 1, 1, 0, 0);
        drive(0, 1, 1, 0, 0);
        idle(5);
        drive(0, 0, 0, 0, 1);
        idle(3);

        // Long service routine: watchdog exit when enabled, otherwise held.
        zin_v = 16'o5252;
        ib_v  = 16'o2030;
        drive(0, 1, 1, 0, 0);
        idle(104);
        drive(1, 0, 0, 0, 0);
        idle(2);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            zin_v = 16'($urandom);
            ib_v  = 16'($urandom);
            drive(($urandom % 128) == 0, ($urandom % 4) == 0, ($urandom % 2) == 1,
                  ($urandom % 4) == 0, ($urandom % 10) == 0);
        end

        drive(1, 0, 0, 0, 0);
        idle(3);
        @(negedge CLK2);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL pending_events got=%0d exp=0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
